// File: rtl/fetch_aligner_if.sv
// fetch_aligner_if: bundles the redirect, memory and instruction handshake signals of the fetch aligner
interface fetch_aligner_if;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_raw_o;
  logic [31:0] instr_pc_o;
  logic        instr_compressed_o;
  modport master (
    input  flush_i, flush_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_raw_o, instr_pc_o, instr_compressed_o
  );
  modport slave (
    output flush_i, flush_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_raw_o, instr_pc_o, instr_compressed_o
  );
endinterface

// File: rtl/fetch_aligner.sv
// fetch_aligner: word fetch sequencer with a 3-halfword queue extracting mixed 16/32-bit instructions
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst,
  fetch_aligner_if.master bus
);
  typedef enum logic [1:0] {RUN, WAIT, DRAIN} state_t;
  state_t      state;
  logic [15:0] q [3];
  logic [15:0] qn [3];
  logic [15:0] ph [2];
  logic [1:0]  count, pop_n, push_n, rem;
  logic [31:0] fetch_addr, out_pc;
  logic        skip_low, is32, valid, req, take, fire;
  assign is32   = q[0][1:0] == 2'b11;
  assign valid  = !rst && !bus.flush_i && (is32 ? count >= 2'd2 : count != 2'd0);
  assign req    = !rst && state == RUN && count <= 2'd1 && !bus.flush_i;
  assign take   = state == WAIT && bus.imem_rvalid_i;
  assign fire   = valid && bus.instr_ready_i;
  assign pop_n  = fire ? (is32 ? 2'd2 : 2'd1) : 2'd0;
  assign push_n = take ? (skip_low ? 2'd1 : 2'd2) : 2'd0;
  assign rem    = count - pop_n;
  assign ph[0]  = skip_low ? bus.imem_rdata_i[31:16] : bus.imem_rdata_i[15:0];
  assign ph[1]  = bus.imem_rdata_i[31:16];
  // Next queue: surviving entries shift down by the pop amount, new halfwords land right after them.
  // Only one request is ever in flight and it issues with count<=1, so the queue never overflows.
  for (genvar i = 0; i < 3; i++) begin : g_q
    logic [2:0] k;
    assign k     = 3'(i) + {1'b0, pop_n};
    assign qn[i] = k < {1'b0, count} ? q[k[1:0]] : ph[k[0] ^ count[0]];
  end
  assign bus.imem_req_o         = req;
  assign bus.imem_addr_o        = rst ? 32'h0 : fetch_addr;
  assign bus.instr_valid_o      = valid;
  assign bus.instr_raw_o        = rst ? 32'h0 : is32 ? {q[1], q[0]} : {q[0], 16'h0000};
  assign bus.instr_pc_o         = rst ? 32'h0 : out_pc;
  assign bus.instr_compressed_o = !rst && !is32;
  // Fetch FSM, halfword queue and PC tracking; a redirect beats response, handshake and grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      count      <= 2'd0;
      fetch_addr <= {RESET_PC[31:2], 2'b00};
      skip_low   <= RESET_PC[1];
      out_pc     <= {RESET_PC[31:1], 1'b0};
    end else if (bus.flush_i) begin
      count      <= 2'd0;
      out_pc     <= bus.flush_pc_i & ~32'd1;
      fetch_addr <= bus.flush_pc_i & ~32'd3;
      skip_low   <= bus.flush_pc_i[1];
      state      <= bus.imem_rvalid_i ? RUN : state == WAIT ? DRAIN : state;
    end else begin
      q      <= qn;
      count  <= rem + push_n;
      out_pc <= out_pc + {29'd0, pop_n, 1'b0};
      if (req && bus.imem_gnt_i) begin
        state      <= WAIT;
        fetch_addr <= fetch_addr + 32'd4;
      end else if (state != RUN && bus.imem_rvalid_i) begin
        state <= RUN;
        if (state == WAIT) skip_low <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner: random and directed stimulus checked against an instruction-stream model of memory
module tb_fetch_aligner;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_aligner_if bus();
  fetch_aligner #(.RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {logic [31:0] raw; logic [31:0] pc; logic comp; int resp;} out_t;
  out_t        seen[$];
  logic [31:0] gaddr[$];
  logic [31:0] mem [64];
  logic [31:0] mpc, p_addr, cap_raw, cap_pc, fpc;
  logic        pend, p_req, p_gnt, cap_comp;
  logic [31:0] pend_addr;
  int          checks = 0, errors = 0, lat, lat_max, resp_n, idle;
  function automatic logic [15:0] hw(input logic [31:0] a);
    return a[1] ? mem[a[7:2]][31:16] : mem[a[7:2]][15:0];
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic f, input logic [31:0] fp, input logic rdy, input logic g);
    logic [15:0] h;
    logic [31:0] eraw;
    logic        ec;
    @(negedge clk);
    rst = r;
    bus.flush_i = f;
    bus.flush_pc_i = fp;
    bus.instr_ready_i = rdy;
    bus.imem_gnt_i = g;
    bus.imem_rvalid_i = pend && lat == 0 && !r;
    bus.imem_rdata_i = bus.imem_rvalid_i ? mem[pend_addr[7:2]] : $urandom;
    #1;
    if (r) begin
      check("rst_valid", {31'd0, bus.instr_valid_o}, 0);
      check("rst_req", {31'd0, bus.imem_req_o}, 0);
      check("rst_addr", bus.imem_addr_o, 0);
    end else begin
      if (bus.imem_req_o) begin
        check("addr_align", {30'd0, bus.imem_addr_o[1:0]}, 0);
        check("one_outstanding", {31'd0, pend}, 0);
      end
      if (p_req && !p_gnt && !f) begin
        check("req_held", {31'd0, bus.imem_req_o}, 1);
        check("addr_stable", bus.imem_addr_o, p_addr);
      end
      if (f) check("flush_valid", {31'd0, bus.instr_valid_o}, 0);
      if (bus.instr_valid_o) begin
        h = hw(mpc);
        ec = h[1:0] != 2'b11;
        eraw = ec ? {h, 16'h0000} : {hw(mpc + 32'd2), h};
        check("raw", bus.instr_raw_o, eraw);
        check("pc", bus.instr_pc_o, mpc);
        check("comp", {31'd0, bus.instr_compressed_o}, {31'd0, ec});
      end
    end
    if (r) begin
      mpc = RESET_PC & ~32'd1;
      pend = 1'b0;
      idle = 0;
    end else if (f) begin
      mpc = fp & ~32'd1;
      idle = 0;
    end else if (bus.instr_valid_o && rdy) begin
      seen.push_back('{bus.instr_raw_o, bus.instr_pc_o, bus.instr_compressed_o, resp_n});
      mpc += ec ? 32'd2 : 32'd4;
      idle = 0;
    end else idle++;
    if (idle > 80) begin
      check("progress", idle, 0);
      idle = 0;
    end
    if (bus.imem_rvalid_i) begin
      pend = 1'b0;
      resp_n++;
    end else if (pend && lat > 0) lat--;
    if (!r && bus.imem_req_o && g) begin
      pend = 1'b1;
      pend_addr = bus.imem_addr_o;
      lat = $urandom_range(0, lat_max);
      gaddr.push_back(bus.imem_addr_o);
    end
    p_req = !r && !f && bus.imem_req_o;
    p_gnt = g;
    p_addr = bus.imem_addr_o;
  endtask
  task automatic reset_dut();
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    seen.delete();
    gaddr.delete();
    resp_n = 0;
  endtask
  task automatic run(input int n);
    repeat (n) step(0, 0, 0, 1, 1);
  endtask
  initial begin
    bus.flush_i = 0;
    bus.flush_pc_i = 0;
    bus.instr_ready_i = 0;
    bus.imem_gnt_i = 0;
    bus.imem_rvalid_i = 0;
    bus.imem_rdata_i = 0;
    pend = 0; p_req = 0; p_gnt = 0; p_addr = 0; lat = 0; resp_n = 0; idle = 0; mpc = 0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    lat_max = 1;
    mem[0] = 32'h00A00513;
    reset_dut();
    run(6);
    check("t1_addr", gaddr[0], 32'h0);
    check("t1_raw", seen[0].raw, 32'h00A00513);
    check("t1_pc", seen[0].pc, 32'h0);
    check("t1_comp", {31'd0, seen[0].comp}, 0);
    mem[0] = 32'h45854501;
    reset_dut();
    run(6);
    check("t2_raw0", seen[0].raw, 32'h45010000);
    check("t2_pc0", seen[0].pc, 32'h0);
    check("t2_comp0", {31'd0, seen[0].comp}, 1);
    check("t2_raw1", seen[1].raw, 32'h45850000);
    check("t2_pc1", seen[1].pc, 32'h2);
    check("t2_comp1", {31'd0, seen[1].comp}, 1);
    check("t2_fetches", seen[1].resp, 1);
    lat_max = 3;
    mem[0] = 32'h05134501;
    mem[1] = 32'h000000A0;
    reset_dut();
    run(15);
    check("t3_raw0", seen[0].raw, 32'h45010000);
    check("t3_pc0", seen[0].pc, 32'h0);
    check("t3_raw1", seen[1].raw, 32'h00A00513);
    check("t3_pc1", seen[1].pc, 32'h2);
    check("t3_comp1", {31'd0, seen[1].comp}, 0);
    check("t3_resp1", seen[1].resp, 2);
    mem[1] = 32'h45810000;
    reset_dut();
    step(0, 0, 0, 1, 1);
    check("t4_inflight", {31'd0, pend}, 1);
    lat = 3;
    step(0, 1, 32'h106, 1, 1);
    seen.delete();
    gaddr.delete();
    for (int i = 0; i < 10 && pend; i++) begin
      step(0, 0, 0, 1, 1);
      check("t4_drain_valid", {31'd0, bus.instr_valid_o}, 0);
      check("t4_drain_req", {31'd0, bus.imem_req_o}, 0);
    end
    run(6);
    check("t4_addr", gaddr[0], 32'h104);
    check("t4_pc", seen[0].pc, 32'h106);
    check("t4_raw", seen[0].raw, 32'h45810000);
    check("t4_comp", {31'd0, seen[0].comp}, 1);
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    reset_dut();
    for (int i = 0; i < 20 && !bus.instr_valid_o; i++) step(0, 0, 0, 0, 1);
    check("t5_valid", {31'd0, bus.instr_valid_o}, 1);
    cap_raw = bus.instr_raw_o;
    cap_pc = bus.instr_pc_o;
    cap_comp = bus.instr_compressed_o;
    repeat (8) begin
      step(0, 0, 0, 0, 1);
      check("t5_hold_valid", {31'd0, bus.instr_valid_o}, 1);
      check("t5_hold_raw", bus.instr_raw_o, cap_raw);
      check("t5_hold_pc", bus.instr_pc_o, cap_pc);
      check("t5_hold_comp", {31'd0, bus.instr_compressed_o}, {31'd0, cap_comp});
    end
    run(30);
    reset_dut();
    run(4);
    step(1, 0, 0, 1, 1);
    repeat (3) begin
      step(0, 0, 0, 1, 0);
      check("t6_valid", {31'd0, bus.instr_valid_o}, 0);
      check("t6_req", {31'd0, bus.imem_req_o}, 1);
      check("t6_addr", bus.imem_addr_o, RESET_PC & ~32'd3);
    end
    run(10);
    for (int i = 0; i < 4000; i++) begin
      fpc = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 255);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 29) == 0, fpc,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
